// File: rtl/fpu_pkg.sv
// Shared FP32 field definitions, flag indices and the buffer entry type for the
// adder result buffer.
package fpu_pkg;

   localparam int SIGN_BIT = 31;
   localparam int EXP_MSB  = 30;
   localparam int EXP_LSB  = 23;
   localparam int FRAC_W   = 23;

   localparam logic [7:0] EXP_ALL_ONES = 8'hFF;

   localparam int FLG_ERR = 0;
   localparam int FLG_OVF = 1;
   localparam int FLG_NAN = 2;

   typedef struct packed {
      logic [31:0] result;
      logic [2:0]  flags;
   } fpu_resbuf_entry_t;

   // A quiet or signalling NaN: all-ones exponent with a non-zero fraction.
   function automatic logic is_nan(input logic [31:0] value);
      return (value[EXP_MSB:EXP_LSB] == EXP_ALL_ONES) && (value[FRAC_W-1:0] != '0);
   endfunction

endpackage

// File: rtl/fpu_sync_fifo.sv
// Single-clock FIFO with an explicit occupancy counter and registered
// full/empty status, so that neither handshake output depends combinationally on an input.
module fpu_sync_fifo #(
   parameter int WIDTH = 35,
   parameter int DEPTH = 4,
   parameter int PTR_W = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_wr_en,
   input  logic [WIDTH-1:0] i_wr_data,
   input  logic             i_rd_en,
   output logic [WIDTH-1:0] o_rd_data,
   output logic             o_full,
   output logic             o_empty,
   output logic [PTR_W:0]   o_count
);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [PTR_W:0]   r_count;
   logic             r_full;
   logic             r_empty;

   logic             w_push;
   logic             w_pop;
   logic [PTR_W:0]   w_count_nxt;

   // A full FIFO refuses writes even when a read is in progress this cycle.
   assign w_push      = i_wr_en && !r_full;
   assign w_pop       = i_rd_en && !r_empty;
   assign w_count_nxt = r_count + {{PTR_W{1'b0}}, w_push} - {{PTR_W{1'b0}}, w_pop};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] <= '0;
         end
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         r_full   <= 1'b0;
         r_empty  <= 1'b1;
      end else begin
         if (w_push) begin
            r_mem[r_wr_ptr] <= i_wr_data;
            r_wr_ptr        <= r_wr_ptr + {{(PTR_W-1){1'b0}}, 1'b1};
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + {{(PTR_W-1){1'b0}}, 1'b1};
         end
         r_count <= w_count_nxt;
         r_full  <= (w_count_nxt == (PTR_W+1)'(DEPTH));
         r_empty <= (w_count_nxt == '0);
      end
   end

   assign o_rd_data = r_mem[r_rd_ptr];
   assign o_full    = r_full;
   assign o_empty   = r_empty;
   assign o_count   = r_count;

endmodule

// File: rtl/fpu_add_result_buffer.sv
// Output buffer behind the FP32 adder: classifies each result, queues it and
// accumulates sticky exception flags. FPU_RESBUF_CNT_EN adds an overflow event counter.
module fpu_add_result_buffer
   import fpu_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int CNT_W = 16
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [31:0]            in_result,
   input  logic                   in_overflow,
   input  logic                   in_error,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [31:0]            out_result,
   output logic [2:0]             out_flags,
   output logic [2:0]             sticky_flags,
   input  logic                   clear_flags,
`ifdef FPU_RESBUF_CNT_EN
   output logic [CNT_W-1:0]       ovf_count,
`endif
   output logic [$clog2(DEPTH):0] count
);

   localparam int EW = $bits(fpu_resbuf_entry_t);

   fpu_resbuf_entry_t w_entry_in;
   fpu_resbuf_entry_t w_entry_out;
   logic [EW-1:0]     w_rd_data;
   logic              w_full;
   logic              w_empty;
   logic              w_push;
   logic [2:0]        r_sticky;

   always_comb begin
      w_entry_in                = '0;
      w_entry_in.result         = in_result;
      w_entry_in.flags[FLG_NAN] = is_nan(in_result);
      w_entry_in.flags[FLG_OVF] = in_overflow;
      w_entry_in.flags[FLG_ERR] = in_error;
   end

   assign in_ready  = !w_full;
   assign out_valid = !w_empty;
   assign w_push    = in_valid && in_ready;

   fpu_sync_fifo #(
      .WIDTH (EW),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_wr_en   (in_valid),
      .i_wr_data (w_entry_in),
      .i_rd_en   (out_ready),
      .o_rd_data (w_rd_data),
      .o_full    (w_full),
      .o_empty   (w_empty),
      .o_count   (count)
   );

   assign w_entry_out = fpu_resbuf_entry_t'(w_rd_data);
   assign out_result  = w_entry_out.result;
   assign out_flags   = w_entry_out.flags;

   // A set arriving in the same cycle as a clear survives the clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sticky <= '0;
      end else begin
         r_sticky <= (clear_flags ? 3'b000 : r_sticky) | (w_push ? w_entry_in.flags : 3'b000);
      end
   end

   assign sticky_flags = r_sticky;

`ifdef FPU_RESBUF_CNT_EN
   logic [CNT_W-1:0] r_ovf_count;
   logic             w_ovf_push;

   assign w_ovf_push = w_push && in_overflow;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ovf_count <= '0;
      end else if (clear_flags) begin
         r_ovf_count <= {{(CNT_W-1){1'b0}}, w_ovf_push};
      end else if (w_ovf_push && (r_ovf_count != {CNT_W{1'b1}})) begin
         r_ovf_count <= r_ovf_count + {{(CNT_W-1){1'b0}}, 1'b1};
      end
   end

   assign ovf_count = r_ovf_count;
`else
   logic w_unused_cnt_w;
   assign w_unused_cnt_w = (CNT_W > 0);
`endif

endmodule

// File: tb/tb_fpu_add_result_buffer.sv
// Scoreboard bench for fpu_add_result_buffer: a queue-based reference model drives
// expectations, and an independent monitor checks every popped entry.
module tb_fpu_add_result_buffer;

   localparam int DEPTH = 4;
   localparam int CNT_W = 16;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] in_result = '0;
   logic        in_overflow = 1'b0;
   logic        in_error = 1'b0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] out_result;
   logic [2:0]  out_flags;
   logic [2:0]  sticky_flags;
   logic        clear_flags = 1'b0;
   logic [2:0]  count;
`ifdef FPU_RESBUF_CNT_EN
   logic [CNT_W-1:0] ovf_count;
`endif

   fpu_add_result_buffer #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .in_result    (in_result),
      .in_overflow  (in_overflow),
      .in_error     (in_error),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_result   (out_result),
      .out_flags    (out_flags),
      .sticky_flags (sticky_flags),
      .clear_flags  (clear_flags),
`ifdef FPU_RESBUF_CNT_EN
      .ovf_count    (ovf_count),
`endif
      .count        (count)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] r;
      logic [2:0]  f;
   } exp_t;

   exp_t        sb[$];
   int          total = 0;
   int          bad = 0;
   int          m_cnt = 0;
   logic [2:0]  m_sticky = '0;
   longint      m_ovf = 0;
   longint      ovf_max = (64'd1 << CNT_W) - 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Expected flags straight from the FP32 encoding rules, using plain arithmetic.
   function automatic logic [2:0] classify(input logic [31:0] r, input logic o, input logic e);
      int unsigned exp_field;
      int unsigned frac;
      logic nan;
      exp_field = (r / (32'd1 << 23)) % 256;
      frac      = r % (32'd1 << 23);
      nan       = (exp_field == 255) && (frac != 0);
      return {nan, o, e};
   endfunction

   // One clock: verify state after the previous edge, then present new inputs and
   // advance the model to the state expected after the coming edge.
   task automatic step(input logic v, input logic [31:0] r, input logic o, input logic e,
                       input logic ordy, input logic clr, output logic acc);
      logic [2:0] f;
      logic       pop;
      exp_t       item;
      @(negedge clk);
      check("count", count, m_cnt);
      check("in_ready", in_ready, (m_cnt < DEPTH));
      check("out_valid", out_valid, (m_cnt > 0));
      check("sticky_flags", sticky_flags, m_sticky);
`ifdef FPU_RESBUF_CNT_EN
      check("ovf_count", ovf_count, m_ovf);
`endif
      in_valid    = v;
      in_result   = r;
      in_overflow = o;
      in_error    = e;
      out_ready   = ordy;
      clear_flags = clr;
      f   = classify(r, o, e);
      acc = v && (m_cnt < DEPTH);
      pop = ordy && (m_cnt > 0);
      if (acc) begin
         item.r = r;
         item.f = f;
         sb.push_back(item);
      end
      m_cnt    = m_cnt + (acc ? 1 : 0) - (pop ? 1 : 0);
      m_sticky = (clr ? 3'b000 : m_sticky) | (acc ? f : 3'b000);
      if (clr) m_ovf = (acc && o) ? 1 : 0;
      else if (acc && o && m_ovf < ovf_max) m_ovf = m_ovf + 1;
   endtask

   task automatic idle(input logic ordy, input int n);
      logic acc;
      for (int i = 0; i < n; i++) step(1'b0, 32'h0, 1'b0, 1'b0, ordy, 1'b0, acc);
   endtask

   // Monitor: compares the head entry whenever the consumer takes it.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         #2;
         if (rst_n && out_valid && out_ready) begin
            if (sb.size() == 0) begin
               check("unexpected_pop", 1, 0);
            end else begin
               e = sb.pop_front();
               check("out_result", out_result, e.r);
               check("out_flags", out_flags, e.f);
            end
         end
      end
   end

   function automatic logic [31:0] rand_value();
      case ($urandom_range(0, 4))
         0:       return 32'h7F800000 | ($urandom % (32'd1 << 23));
         1:       return 32'hFF800000;
         2:       return 32'h7FC00000;
         default: return $urandom;
      endcase
   endfunction

   initial begin
      logic        acc;
      logic [31:0] pend_r;
      logic        pend_o, pend_e, have_pend;
      int          guard;

      #12;
      check("rst_in_ready", in_ready, 1);
      check("rst_out_valid", out_valid, 0);
      check("rst_out_result", out_result, 0);
      check("rst_out_flags", out_flags, 0);
      check("rst_sticky", sticky_flags, 0);
      check("rst_count", count, 0);
`ifdef FPU_RESBUF_CNT_EN
      check("rst_ovf_count", ovf_count, 0);
`endif
      #1 rst_n = 1'b1;

      // Single push, then let it drain.
      step(1'b1, 32'h3F800000, 1'b0, 1'b0, 1'b0, 1'b0, acc);
      idle(1'b0, 1);
      check("single_out_result", out_result, 32'h3F800000);
      check("single_count", count, 1);
      idle(1'b1, 1);

      // Fill with back-pressure; the fifth value is held upstream until accepted.
      for (int i = 0; i < 4; i++) step(1'b1, 32'h40000000 + i, 1'b0, 1'b0, 1'b0, 1'b0, acc);
      step(1'b1, 32'h40000004, 1'b0, 1'b0, 1'b0, 1'b0, acc);
      check("fill_count", count, 4);
      check("fill_in_ready", in_ready, 0);
      guard = 0;
      do begin
         step(1'b1, 32'h40000004, 1'b0, 1'b0, 1'b1, 1'b0, acc);
         guard++;
      end while (!acc && guard < 8);
      check("held_accepted", acc, 1);
      idle(1'b1, 6);

      // NaN and overflow/error classification.
      step(1'b1, 32'h7FC00000, 1'b0, 1'b0, 1'b1, 1'b0, acc);
      step(1'b1, 32'h7F800000, 1'b1, 1'b1, 1'b1, 1'b0, acc);
      idle(1'b1, 1);
      check("sticky_all", sticky_flags, 3'b111);

      // Clear colliding with a push carrying an error.
      step(1'b1, 32'h3F800000, 1'b0, 1'b1, 1'b1, 1'b1, acc);
      idle(1'b1, 1);
      check("clear_vs_set", sticky_flags, 3'b001);
      idle(1'b1, 2);

      // Streaming at occupancy 2 across pointer wrap.
      step(1'b1, 32'h11111111, 1'b0, 1'b0, 1'b0, 1'b0, acc);
      step(1'b1, 32'h22222222, 1'b0, 1'b0, 1'b0, 1'b0, acc);
      for (int i = 0; i < 10; i++) step(1'b1, $urandom, 1'b0, 1'b0, 1'b1, 1'b0, acc);
      check("stream_count", count, 2);
      idle(1'b1, 4);

      // Randomised traffic with a valid held until accepted.
      have_pend = 1'b0;
      pend_r = '0; pend_o = 1'b0; pend_e = 1'b0;
      for (int i = 0; i < 400; i++) begin
         if (!have_pend && ($urandom_range(0, 3) != 0)) begin
            have_pend = 1'b1;
            pend_r = rand_value();
            pend_o = ($urandom_range(0, 3) == 0);
            pend_e = ($urandom_range(0, 4) == 0);
         end
         step(have_pend, pend_r, pend_o, pend_e, ($urandom_range(0, 2) != 0),
              ($urandom_range(0, 15) == 0), acc);
         if (acc) have_pend = 1'b0;
      end
      idle(1'b1, 8);

      // Three overflow pushes queued, then an asynchronous reset mid-cycle.
      step(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b1, acc);
      for (int i = 0; i < 3; i++) step(1'b1, 32'h7F800000, 1'b1, 1'b0, 1'b0, 1'b0, acc);
      idle(1'b0, 1);
      check("queued_count", count, 3);
`ifdef FPU_RESBUF_CNT_EN
      check("queued_ovf_count", ovf_count, 3);
`endif
      #3;
      rst_n = 1'b0;
      in_valid = 1'b0;
      #1;
      check("arst_out_valid", out_valid, 0);
      check("arst_count", count, 0);
      check("arst_sticky", sticky_flags, 0);
      check("arst_in_ready", in_ready, 1);
`ifdef FPU_RESBUF_CNT_EN
      check("arst_ovf_count", ovf_count, 0);
`endif
      sb.delete();
      m_cnt = 0;
      m_sticky = '0;
      m_ovf = 0;
      @(negedge clk);
      #3 rst_n = 1'b1;

      step(1'b1, 32'h40490FDB, 1'b0, 1'b0, 1'b0, 1'b0, acc);
      idle(1'b1, 3);
      check("sb_drained", sb.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
